seg_capture: RTL and testbench

SEG_CAPTURE -- requirements
Module: seg_capture

---
 rtl/seg_capture_pkg.sv | 54 +++++
 rtl/seg_capture_if.sv | 23 ++
 rtl/seg_pattern_dec.sv | 34 +++
 rtl/seg_capture.sv | 148 ++++++++++++++
 tb/tb_seg_capture.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/seg_capture_pkg.sv
// Shared definitions for 7-segment capture and display: segment codes, widths,
// frame payload and digit-select helpers.
package seg_capture_pkg;

  localparam int unsigned DIGITS      = 4;
  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned IDX_W       = 2;
  localparam int unsigned SEG_W       = 7;
  localparam int unsigned LED_W       = SEG_W + 1;
  localparam int unsigned DATA_W      = DIGITS * DIGIT_W;

  // Active-low common-anode patterns, bit order g..a
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [DIGIT_W-1:0] BCD_INVALID = 4'hF;

  typedef enum logic {
    ST_SETTLING,
    ST_SAMPLED
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DIGITS-1:0] point;
    logic [DIGITS-1:0] blank;
  } frame_t;

  localparam frame_t FRAME_RST = '{data: '0, point: '0, blank: '1};

  // A select is usable only when exactly one active-low line is asserted
  function automatic logic sel_valid(input logic [DIGITS-1:0] sel);
    return $countones(~sel) == 1;
  endfunction

  function automatic logic [IDX_W-1:0] sel_index(input logic [DIGITS-1:0] sel);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!sel[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_capture_if.sv
// Multiplexed display pins in, captured frame and status out.
interface seg_capture_if;
  import seg_capture_pkg::*;

  logic [DIGITS-1:0] seg_sel;
  logic [LED_W-1:0]  seg_led;
  logic [DATA_W-1:0] data;
  logic [DIGITS-1:0] point;
  logic [DIGITS-1:0] blank;
  logic              frame_valid;
  logic              seg_err;
  logic              stale;

  modport master (
    output seg_sel, seg_led,
    input  data, point, blank, frame_valid, seg_err, stale
  );

  modport slave (
    input  seg_sel, seg_led,
    output data, point, blank, frame_valid, seg_err, stale
  );
endinterface

// File: rtl/seg_pattern_dec.sv
// Combinational 7-segment pattern to BCD decoder; flags dark and unrecognised patterns.
module seg_pattern_dec
  import seg_capture_pkg::*;
(
  input  logic [SEG_W-1:0]   pattern,
  output logic [DIGIT_W-1:0] value,
  output logic               blank,
  output logic               invalid
);

  always_comb begin
    value   = BCD_INVALID;
    blank   = 1'b0;
    invalid = 1'b0;
    case (pattern)
      SEG_0:     value = DIGIT_W'(0);
      SEG_1:     value = DIGIT_W'(1);
      SEG_2:     value = DIGIT_W'(2);
      SEG_3:     value = DIGIT_W'(3);
      SEG_4:     value = DIGIT_W'(4);
      SEG_5:     value = DIGIT_W'(5);
      SEG_6:     value = DIGIT_W'(6);
      SEG_7:     value = DIGIT_W'(7);
      SEG_8:     value = DIGIT_W'(8);
      SEG_9:     value = DIGIT_W'(9);
      SEG_BLANK: begin
        value = DIGIT_W'(0);
        blank = 1'b1;
      end
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// Snoops a multiplexed 4-digit 7-segment display and reassembles complete BCD frames,
// sampling each digit once its select and pattern have been stable long enough.
module seg_capture
  import seg_capture_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned STALE_CYCLES  = 2_000_000
) (
  input  logic         clk,
  input  logic         sys_reset,
  seg_capture_if.slave bus
);

  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned STALE_W  = $clog2(STALE_CYCLES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [STALE_W-1:0]  STALE_MAX   = STALE_W'(STALE_CYCLES);

  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [LED_W-1:0]    led_q, led_d;
  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  frame_t              shadow_q, shadow_d;
  frame_t              frame_q, frame_d;
  logic                frame_valid_q, frame_valid_d;
  logic                seg_err_q, seg_err_d;
  logic [STALE_W-1:0]  stale_cnt_q, stale_cnt_d;
  logic                stale_q, stale_d;

  logic               sel_ok;
  logic               changed;
  logic               sample;
  logic               full;
  logic [IDX_W-1:0]   idx;
  logic [DIGIT_W-1:0] dec_value;
  logic               dec_blank;
  logic               dec_invalid;

  seg_pattern_dec u_dec (
    .pattern (led_q[SEG_W-1:0]),
    .value   (dec_value),
    .blank   (dec_blank),
    .invalid (dec_invalid)
  );

  // Input stage plus change detection against the incoming pins
  always_comb begin
    sel_d   = bus.seg_sel;
    led_d   = bus.seg_led;
    changed = (sel_d != sel_q) || (led_d != led_q);
    sel_ok  = sel_valid(sel_q);
    idx     = sel_index(sel_q);
  end

  // Settle FSM: one sample per stable select period
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    sample   = 1'b0;
    case (state_q)
      ST_SETTLING: begin
        if (!sel_ok || changed) begin
          settle_d = '0;
        end else if (settle_q == SETTLE_LAST) begin
          sample  = 1'b1;
          state_d = ST_SAMPLED;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      ST_SAMPLED: begin
        if (!sel_ok || changed) begin
          state_d  = ST_SETTLING;
          settle_d = '0;
        end
      end
      default: begin
        state_d  = ST_SETTLING;
        settle_d = '0;
      end
    endcase
  end

  // Shadow assembly; a full mask publishes the frame one cycle after the last sample
  always_comb begin
    full          = (mask_q == '1);
    mask_d        = full ? '0 : mask_q;
    shadow_d      = shadow_q;
    frame_d       = full ? shadow_q : frame_q;
    frame_valid_d = full;
    seg_err_d     = seg_err_q;
    if (sample) begin
      mask_d[idx]                           = 1'b1;
      shadow_d.data[{idx, 2'b00} +: DIGIT_W] = dec_value;
      shadow_d.point[idx]                   = ~led_q[LED_W-1];
      shadow_d.blank[idx]                   = dec_blank;
      seg_err_d                             = seg_err_q | dec_invalid;
    end
  end

  // Stale watchdog restarts on the same edge that raises frame_valid
  always_comb begin
    stale_cnt_d = stale_cnt_q;
    if (full) begin
      stale_cnt_d = '0;
    end else if (stale_cnt_q != STALE_MAX) begin
      stale_cnt_d = stale_cnt_q + STALE_W'(1);
    end
    stale_d = (stale_cnt_d == STALE_MAX);
  end

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      sel_q         <= '1;
      led_q         <= '1;
      state_q       <= ST_SETTLING;
      settle_q      <= '0;
      mask_q        <= '0;
      shadow_q      <= FRAME_RST;
      frame_q       <= FRAME_RST;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      stale_cnt_q   <= '0;
      stale_q       <= 1'b0;
    end else begin
      sel_q         <= sel_d;
      led_q         <= led_d;
      state_q       <= state_d;
      settle_q      <= settle_d;
      mask_q        <= mask_d;
      shadow_q      <= shadow_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      seg_err_q     <= seg_err_d;
      stale_cnt_q   <= stale_cnt_d;
      stale_q       <= stale_d;
    end
  end

  assign bus.data        = frame_q.data;
  assign bus.point       = frame_q.point;
  assign bus.blank       = frame_q.blank;
  assign bus.frame_valid = frame_valid_q;
  assign bus.seg_err     = seg_err_q;
  assign bus.stale       = stale_q;

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: scans digit patterns onto the snooped pins and
// checks captured frames, latency, error stickiness, glitch rejection, reset and stale.
module tb_seg_capture;

  logic clk = 1'b0;
  logic sys_reset;

  seg_capture_if bus ();

  seg_capture #(
    .SETTLE_CYCLES (4),
    .STALE_CYCLES  (100)
  ) dut (
    .clk       (clk),
    .sys_reset (sys_reset),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          fv_cnt = 0;
  logic [15:0] snap_data;
  logic [3:0]  snap_point;
  logic [3:0]  snap_blank;
  logic        snap_stale;
  logic        snap_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, observe 1 ns after the edge, and snapshot any frame pulse
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.frame_valid === 1'b1) begin
      fv_cnt++;
      snap_data  = bus.data;
      snap_point = bus.point;
      snap_blank = bus.blank;
      snap_stale = bus.stale;
      snap_err   = bus.seg_err;
    end
  endtask

  task automatic drive(input int i, input logic [7:0] led);
    bus.seg_sel = ~(4'b0001 << i);
    bus.seg_led = led;
  endtask

  task automatic show(input int i, input logic [7:0] led, input int n);
    drive(i, led);
    repeat (n) tick();
  endtask

  task automatic scan(input logic [7:0] l0, input logic [7:0] l1,
                      input logic [7:0] l2, input logic [7:0] l3, input int n);
    show(0, l0, n);
    show(1, l1, n);
    show(2, l2, n);
    show(3, l3, n);
  endtask

  // Ticks until a new frame pulse; k = ticks taken, -1 if the bound expires
  task automatic wait_frame(input int max, output int k);
    int start;
    start = fv_cnt;
    k = 0;
    while (fv_cnt == start && k < max) begin
      tick();
      k++;
    end
    if (fv_cnt == start) k = -1;
  endtask

  int k;
  int j;

  initial begin
    sys_reset   = 1'b1;
    bus.seg_sel = 4'hF;
    bus.seg_led = 8'hFF;
    repeat (3) tick();
    chk("rst_data",  32'(bus.data), 32'h0000);
    chk("rst_point", 32'(bus.point), 32'h0);
    chk("rst_blank", 32'(bus.blank), 32'hF);
    chk("rst_fv",    32'(bus.frame_valid), 32'h0);
    chk("rst_err",   32'(bus.seg_err), 32'h0);
    chk("rst_stale", 32'(bus.stale), 32'h0);
    sys_reset = 1'b0;
    tick();

    // 1234 with dp on digit 2, slow scan, latency from digit 3 select
    fv_cnt = 0;
    show(0, 8'h99, 250);
    show(1, 8'hB0, 250);
    show(2, 8'h24, 250);
    drive(3, 8'hF9);
    wait_frame(50, k);
    chk("latency", 32'(k), 32'd6);
    tick();
    chk("fv_one_cycle", 32'(bus.frame_valid), 32'h0);
    chk("f1_data",  32'(bus.data), 32'h1234);
    chk("f1_point", 32'(bus.point), 32'h4);
    chk("f1_blank", 32'(bus.blank), 32'h0);
    chk("f1_err",   32'(bus.seg_err), 32'h0);
    repeat (240) tick();
    chk("f1_count", 32'(fv_cnt), 32'd1);
    chk("stale_after_gap", 32'(bus.stale), 32'h1);

    // Dark digit 3
    fv_cnt = 0;
    scan(8'hC0, 8'h90, 8'h92, 8'hFF, 20);
    chk("f2_count", 32'(fv_cnt), 32'd1);
    chk("f2_data",  32'(snap_data), 32'h0590);
    chk("f2_blank", 32'(snap_blank), 32'h8);
    chk("f2_point", 32'(snap_point), 32'h0);
    chk("f2_stale_clr", 32'(snap_stale), 32'h0);

    // Unrecognised pattern on digit 1, then a clean frame
    fv_cnt = 0;
    scan(8'hC0, 8'h55, 8'hC0, 8'hC0, 20);
    chk("f3_count", 32'(fv_cnt), 32'd1);
    chk("f3_data",  32'(snap_data), 32'h00F0);
    chk("f3_point", 32'(snap_point), 32'h2);
    chk("f3_err",   32'(bus.seg_err), 32'h1);
    fv_cnt = 0;
    scan(8'h99, 8'hB0, 8'h24, 8'hF9, 20);
    chk("f4_data",    32'(snap_data), 32'h1234);
    chk("f4_err_sticky", 32'(snap_err), 32'h1);

    // Invalid select then a jittering pattern: digit 0 must never be sampled
    fv_cnt = 0;
    bus.seg_sel = 4'b1100;
    bus.seg_led = 8'hC0;
    repeat (3) tick();
    bus.seg_sel = 4'b1110;
    for (int r = 0; r < 10; r++) begin
      bus.seg_led = r[0] ? 8'hF9 : 8'hC0;
      repeat (2) tick();
    end
    show(1, 8'hB0, 20);
    show(2, 8'hA4, 20);
    show(3, 8'hF9, 20);
    chk("glitch_no_frame", 32'(fv_cnt), 32'd0);
    show(0, 8'hF8, 20);
    chk("f5_count", 32'(fv_cnt), 32'd1);
    chk("f5_data",  32'(snap_data), 32'h1237);

    // Reset after two digits discards the partial frame
    fv_cnt = 0;
    show(0, 8'h99, 20);
    show(1, 8'hB0, 20);
    sys_reset   = 1'b1;
    bus.seg_sel = 4'hF;
    bus.seg_led = 8'hFF;
    repeat (2) tick();
    chk("mid_rst_data",  32'(bus.data), 32'h0000);
    chk("mid_rst_blank", 32'(bus.blank), 32'hF);
    chk("mid_rst_err",   32'(bus.seg_err), 32'h0);
    sys_reset = 1'b0;
    tick();
    show(2, 8'hA4, 20);
    show(3, 8'hF9, 20);
    chk("post_rst_partial", 32'(fv_cnt), 32'd0);
    show(0, 8'h99, 20);
    show(1, 8'hB0, 20);
    chk("post_rst_count", 32'(fv_cnt), 32'd1);
    chk("post_rst_data",  32'(snap_data), 32'h1234);

    // Scan stops: stale exactly 100 cycles after the last frame pulse
    fv_cnt = 0;
    show(2, 8'hA4, 20);
    show(3, 8'hF9, 20);
    show(0, 8'h99, 20);
    drive(1, 8'hB0);
    wait_frame(50, k);
    chk("f6_latency", 32'(k), 32'd6);
    bus.seg_sel = 4'hF;
    bus.seg_led = 8'hFF;
    j = 0;
    while (bus.stale !== 1'b1 && j < 300) begin
      tick();
      j++;
    end
    chk("stale_delay", 32'(j), 32'd100);
    repeat (50) tick();
    chk("stale_saturated", 32'(bus.stale), 32'h1);
    fv_cnt = 0;
    scan(8'h99, 8'hB0, 8'h24, 8'hF9, 20);
    chk("resume_count", 32'(fv_cnt), 32'd1);
    chk("resume_stale_at_fv", 32'(snap_stale), 32'h0);
    chk("resume_stale_now",   32'(bus.stale), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
